// File: rtl/sync_fifo_buffer_pkg.sv
// Shared constants and default-sized types for the single-clock FIFO.
// Modules with non-default parameters size their own signals from PTR_WIDTH.
package sync_fifo_buffer_pkg;

    localparam int FIFO_STD  = 0;
    localparam int FIFO_FWFT = 1;

    localparam int DEF_DEPTH      = 16;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_PTR_WIDTH  = $clog2(DEF_DEPTH);

    typedef logic [DEF_PTR_WIDTH:0]    ptr_t;
    typedef logic [DEF_PTR_WIDTH:0]    count_t;
    typedef logic [DEF_DATA_WIDTH-1:0] data_t;

endpackage

// File: rtl/sync_fifo_buffer_if.sv
// Producer/consumer-side bundle of the FIFO.
// The master modport drives requests; the slave modport is the FIFO itself.
interface sync_fifo_buffer_if
    import sync_fifo_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int PTR_WIDTH  = DEF_PTR_WIDTH
);
    logic                  i_we;
    logic [DATA_WIDTH-1:0] i_data_in;
    logic                  i_re;
    logic                  i_err_clr;
    logic [DATA_WIDTH-1:0] o_data_out;
    logic                  o_full;
    logic                  o_empty;
    logic                  o_almost_full;
    logic                  o_almost_empty;
    logic [PTR_WIDTH:0]    o_count;
    logic                  o_overflow;
    logic                  o_underflow;

    modport master (
        output i_we, i_data_in, i_re, i_err_clr,
        input  o_data_out, o_full, o_empty, o_almost_full, o_almost_empty,
               o_count, o_overflow, o_underflow
    );

    modport slave (
        input  i_we, i_data_in, i_re, i_err_clr,
        output o_data_out, o_full, o_empty, o_almost_full, o_almost_empty,
               o_count, o_overflow, o_underflow
    );
endinterface

// File: rtl/sync_fifo_buffer_mem_ram.sv
// Simple dual-port storage: unreset array, registered read port with enable.
// The read register is reset so the FIFO output starts at zero.
module sync_fifo_buffer_mem_ram
    import sync_fifo_buffer_pkg::*;
#(
    parameter int DEPTH      = DEF_DEPTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int PTR_WIDTH  = DEF_PTR_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_we,
    input  logic [PTR_WIDTH-1:0]  i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_re,
    input  logic [PTR_WIDTH-1:0]  i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/sync_fifo_buffer.sv
// Single-clock FIFO: pointer/count/flag control around a dual-port RAM, with
// optional first-word-fall-through where the RAM read register holds the head word.
module sync_fifo_buffer
    import sync_fifo_buffer_pkg::*;
#(
    parameter int DEPTH         = DEF_DEPTH,
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int PTR_WIDTH     = $clog2(DEPTH),
    parameter int FWFT          = FIFO_STD,
    parameter int AFULL_THRESH  = DEPTH - 2,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic               i_clk,
    input  logic               i_rst,
    sync_fifo_buffer_if.slave  bus
);

    localparam logic [PTR_WIDTH:0] C_ONE    = (PTR_WIDTH+1)'(1);
    localparam logic [PTR_WIDTH:0] C_DEPTH  = (PTR_WIDTH+1)'(DEPTH);
    localparam logic [PTR_WIDTH:0] C_AFULL  = (PTR_WIDTH+1)'(AFULL_THRESH);
    localparam logic [PTR_WIDTH:0] C_AEMPTY = (PTR_WIDTH+1)'(AEMPTY_THRESH);

    logic [PTR_WIDTH:0]    r_wptr;
    logic [PTR_WIDTH:0]    r_rptr;
    logic [PTR_WIDTH:0]    r_count;
    logic                  r_valid;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_mem_empty;
    logic                  w_ptr_full;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic                  w_mem_rd;
    logic [DATA_WIDTH-1:0] w_rdata;

    always_comb begin
        w_mem_empty = (r_wptr == r_rptr);
        w_ptr_full  = (r_wptr[PTR_WIDTH] != r_rptr[PTR_WIDTH]) &&
                      (r_wptr[PTR_WIDTH-1:0] == r_rptr[PTR_WIDTH-1:0]);
        // In FWFT mode one word may sit in the output register, so capacity
        // is judged on the total count rather than on the RAM pointers alone.
        if (FWFT == FIFO_FWFT) begin
            w_full  = (r_count == C_DEPTH);
            w_empty = !r_valid;
        end else begin
            w_full  = w_ptr_full;
            w_empty = (r_count == '0);
        end
        w_wr_acc = bus.i_we && !w_full;
        w_rd_acc = bus.i_re && !w_empty;
        if (FWFT == FIFO_FWFT) begin
            w_mem_rd = !w_mem_empty && (!r_valid || w_rd_acc);
        end else begin
            w_mem_rd = w_rd_acc;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_valid     <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wptr <= r_wptr + C_ONE;
            end
            if (w_mem_rd) begin
                r_rptr <= r_rptr + C_ONE;
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + C_ONE;
                2'b01:   r_count <= r_count - C_ONE;
                default: r_count <= r_count;
            endcase
            if (w_mem_rd) begin
                r_valid <= 1'b1;
            end else if (w_rd_acc) begin
                r_valid <= 1'b0;
            end
            // A new error in the same cycle wins over the clear.
            if (bus.i_we && w_full) begin
                r_overflow <= 1'b1;
            end else if (bus.i_err_clr) begin
                r_overflow <= 1'b0;
            end
            if (bus.i_re && w_empty) begin
                r_underflow <= 1'b1;
            end else if (bus.i_err_clr) begin
                r_underflow <= 1'b0;
            end
        end
    end

    sync_fifo_buffer_mem_ram #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .PTR_WIDTH  (PTR_WIDTH)
    ) u_mem (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_we    (w_wr_acc),
        .i_waddr (r_wptr[PTR_WIDTH-1:0]),
        .i_wdata (bus.i_data_in),
        .i_re    (w_mem_rd),
        .i_raddr (r_rptr[PTR_WIDTH-1:0]),
        .o_rdata (w_rdata)
    );

    assign bus.o_data_out     = w_rdata;
    assign bus.o_full         = w_full;
    assign bus.o_empty        = w_empty;
    assign bus.o_almost_full  = (r_count >= C_AFULL);
    assign bus.o_almost_empty = (r_count <= C_AEMPTY);
    assign bus.o_count        = r_count;
    assign bus.o_overflow     = r_overflow;
    assign bus.o_underflow    = r_underflow;

endmodule
